// File: rtl/freq_meter_pkg.sv
// Shared encodings and helpers for the frequency-meter control path:
// sequencer state codes, gate-range encoding and the gate-length lookup.
package freq_meter_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_GATE   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_STORE  = 3'd5;
  localparam logic [2:0] ST_HOLD   = 3'd6;

  typedef enum logic [1:0] {
    RNG_1S    = 2'b00,
    RNG_100MS = 2'b01,
    RNG_10MS  = 2'b10,
    RNG_1MS   = 2'b11
  } range_t;

  // Timed-gate length in clock cycles; clk_hz is always a parameter, so this folds to constants.
  function automatic int unsigned gate_len(input range_t r, input int unsigned clk_hz);
    case (r)
      RNG_1S:    return clk_hz;
      RNG_100MS: return clk_hz / 10;
      RNG_10MS:  return clk_hz / 100;
      default:   return clk_hz / 1000;
    endcase
  endfunction

endpackage

// File: rtl/gate_sequencer_if.sv
// Control/status bundle between the gate sequencer and its surroundings
// (run/mode/range controls, sig_in, counter overflow, gate/clear/store outputs).
interface gate_sequencer_if;
  logic       run;
  logic       measure_mode;
  logic [1:0] F_sel;
  logic       sig_in;
  logic       OF;
  logic       gate;
  logic       clr_cnt;
  logic       Store;
  logic       busy;
  logic       timeout;
  logic [1:0] range_o;

  modport master (
    output run, measure_mode, F_sel, sig_in, OF,
    input  gate, clr_cnt, Store, busy, timeout, range_o
  );

  modport slave (
    input  run, measure_mode, F_sel, sig_in, OF,
    output gate, clr_cnt, Store, busy, timeout, range_o
  );
endinterface

// File: rtl/gate_sequencer_edge_sync.sv
// edge_sync: two-flop synchroniser for an asynchronous input followed by a
// registered rising-edge pulse (3 clocks from sampled edge to pulse consumer).
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  // sh[1:0] is the synchroniser chain, sh[2] the previous synchronised value
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], d};
      rise <= sh[1] & ~sh[2];
    end
  end
endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer: measurement-cycle controller (clear -> gate -> settle -> store -> hold).
// Build option AUTO_RANGE_EN: an overflowed timed gate retries on the next shorter range.
module gate_sequencer
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned HOLD_CYC   = CLK_HZ / 4,
  parameter int unsigned TO_CYC     = 2 * CLK_HZ
) (
  input logic             CLK_50,
  input logic             nRST,
  gate_sequencer_if.slave bus
);

  localparam int CW = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] CLR_M1    = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_M1   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_M1     = CW'(TO_CYC - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] glen_m1;
  logic          mode_q;
  range_t        rng_q;
  logic          rise;
  logic          to_hit;
  logic          retry;
  logic          enter_clr;

  edge_sync u_sync (
    .clk   (CLK_50),
    .rst_n (nRST),
    .d     (bus.sig_in),
    .rise  (rise)
  );

  assign glen_m1   = CW'(gate_len(rng_q, CLK_HZ) - 1);
  assign enter_clr = (state_nx == ST_CLEAR) && (state != ST_CLEAR);

`ifdef AUTO_RANGE_EN
  logic ovf_seen;

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST)                          ovf_seen <= 1'b0;
    else if (state == ST_CLEAR)         ovf_seen <= 1'b0;
    else if (state == ST_GATE && bus.OF) ovf_seen <= 1'b1;
  end

  // Only timed gates retry, and the 1 ms range is the last resort.
  assign retry = ovf_seen && !mode_q && (rng_q != RNG_1MS);
`else
  assign retry = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    to_hit   = 1'b0;
    unique case (state)
      ST_IDLE:   if (bus.run) state_nx = ST_CLEAR;
      ST_CLEAR:  if (cnt == CLR_M1) state_nx = mode_q ? ST_ARM : ST_GATE;
      ST_ARM: begin
        if (rise) state_nx = ST_GATE;
        else if (cnt == TO_M1) begin
          to_hit   = 1'b1;
          state_nx = bus.run ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_GATE: begin
        if (!mode_q) begin
          if (cnt == glen_m1) state_nx = ST_SETTLE;
        end else if (rise) begin
          state_nx = ST_SETTLE;
        end else if (cnt == TO_M1) begin
          to_hit   = 1'b1;
          state_nx = bus.run ? ST_CLEAR : ST_IDLE;
        end
      end
      ST_SETTLE: if (cnt == SETTLE_M1) state_nx = retry ? ST_CLEAR : ST_STORE;
      ST_STORE:  state_nx = ST_HOLD;
      ST_HOLD:   if (cnt == HOLD_M1) state_nx = bus.run ? ST_CLEAR : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // One shared cycle counter, restarted on every state change.
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bus.timeout <= 1'b0;
      bus.range_o <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= (state_nx != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
      bus.timeout <= to_hit;
      if (state_nx == ST_STORE) bus.range_o <= rng_q;
    end
  end

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      mode_q <= 1'b0;
      rng_q  <= RNG_1S;
    end else if (enter_clr) begin
      mode_q <= bus.measure_mode;
`ifdef AUTO_RANGE_EN
      // F_sel seeds the range only when a run starts; retries step it down.
      if (state == ST_IDLE)        rng_q <= range_t'(bus.F_sel);
      else if (state == ST_SETTLE) rng_q <= range_t'(rng_q + 2'd1);
`else
      rng_q <= range_t'(bus.F_sel);
`endif
    end
  end

  assign bus.gate    = (state == ST_GATE);
  assign bus.clr_cnt = (state == ST_CLEAR);
  assign bus.Store   = (state == ST_STORE);
  assign bus.busy    = (state != ST_IDLE);

endmodule
